// File: rtl/key_led_ctrl.sv
// key_led_ctrl: push-button to LED sequencer (OFF -> ON -> BLINK -> OFF).
// Latency: key_in edge to mode/led_out change is DEBOUNCE_CYCLES+3 edges (+1 worst case for async sampling).
// Backpressure: none; every accepted press is consumed on the cycle it is presented.
//
// Ports:
//   clk          single system clock, rising-edge
//   rstn         synchronous active-low reset
//   key_in       raw asynchronous button, 1 = pressed
//   led_out      registered LED drive
//   mode         registered mode: 00 OFF, 01 ON, 10 BLINK
//   press_pulse  registered one-cycle event per accepted press
//
// Optional feature macro: KEY_LONG_PRESS_EN (holding the key LONG_PRESS_CYCLES forces OFF).
module key_led_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int BLINK_HALF        = 3,
  parameter int LONG_PRESS_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       press_pulse
);

  if (DEBOUNCE_CYCLES < 1 || BLINK_HALF < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_param
    $error("key_led_ctrl: all cycle-count parameters must be >= 1");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  // Accept/wrap when the counter sits one below its limit: the increment
  // would reach the limit on this edge.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] BL_ONE  = BW'(1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10
  } mode_e;

  logic          k1_q, k2_q;
  logic          key_stable_q, key_stable_d;
  logic          key_prev_q;  // key_stable delayed one cycle, for rising-edge detect
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press_pulse_q, press_pulse_d;
  mode_e         state_q, state_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          led_q, led_d;
  logic          long_fire;

  // Debounce: count consecutive cycles the synchronised key disagrees with
  // the stable level; any agreement restarts the count.
  always_comb begin
    db_cnt_d     = '0;
    key_stable_d = key_stable_q;
    if (k2_q != key_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_stable_d = k2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  assign press_pulse_d = key_stable_q & ~key_prev_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // Saturating at the limit is what makes the force-OFF fire once per hold.
  always_comb begin
    hold_cnt_d = '0;
    if (key_stable_q) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
    end
  end

  assign long_fire = key_stable_q && (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign long_fire = 1'b0;
`endif

  // Mode FSM plus blink generator; led is derived from next-state values so
  // it moves on the same edge as mode.
  always_comb begin
    state_d       = state_q;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    led_d         = 1'b0;

    if (press_pulse_q) begin
      case (state_q)
        MODE_OFF:   state_d = MODE_ON;
        MODE_ON:    state_d = MODE_BLINK;
        MODE_BLINK: state_d = MODE_OFF;
        default:    state_d = MODE_OFF;
      endcase
    end
    // Long hold overrides a coincident press.
    if (long_fire) begin
      state_d = MODE_OFF;
    end

    if (state_d == MODE_BLINK) begin
      if (state_q != MODE_BLINK) begin
        // Entry starts a full high half-period.
        blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BL_LAST) begin
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BL_ONE;
        blink_phase_d = blink_phase_q;
      end
    end

    case (state_d)
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = blink_phase_d;
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      k1_q          <= 1'b0;
      k2_q          <= 1'b0;
      key_stable_q  <= 1'b0;
      key_prev_q    <= 1'b0;
      db_cnt_q      <= '0;
      press_pulse_q <= 1'b0;
      state_q       <= MODE_OFF;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_q         <= 1'b0;
    end else begin
      k1_q          <= key_in;
      k2_q          <= k1_q;
      key_stable_q  <= key_stable_d;
      key_prev_q    <= key_stable_q;
      db_cnt_q      <= db_cnt_d;
      press_pulse_q <= press_pulse_d;
      state_q       <= state_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_d;
    end
  end

  assign led_out     = led_q;
  assign mode        = state_q;
  assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: directed + randomized bench for key_led_ctrl.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_key_led_ctrl;

  localparam int D = 4;
  localparam int H = 3;
  localparam int L = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_in;
  logic       led_out;
  logic [1:0] mode;
  logic       press_pulse;

  always #5 clk = ~clk;

  key_led_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_HALF(H),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .key_in(key_in),
    .led_out(led_out),
    .mode(mode),
    .press_pulse(press_pulse)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: sync chain, a window of recent synchronised
  // samples, press count modulo 3, and time since BLINK entry.
  bit m_k1, m_k2, m_stable, m_prev, m_pulse, m_led;
  int m_mode, m_blink_t, m_hold;
  bit win[$];

  logic [1:0] log_mode[$];
  logic       log_led[$];
  logic       log_pulse[$];

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_edge(input bit key, input bit rst_n);
    bit all_diff;
    bit fire;
    int new_mode;
    if (!rst_n) begin
      m_k1 = 0; m_k2 = 0; m_stable = 0; m_prev = 0; m_pulse = 0; m_led = 0;
      m_mode = 0; m_blink_t = 0; m_hold = 0;
      win.delete();
      return;
    end
    // Stable level flips once the last D synchronised samples all disagree.
    win.push_back(m_k2);
    if (win.size() > D) win.delete(0);
    all_diff = (win.size() == D);
    foreach (win[i]) if (win[i] == m_stable) all_diff = 0;

    fire = 0;
`ifdef KEY_LONG_PRESS_EN
    if (m_stable) begin
      if (m_hold < L) begin
        m_hold++;
        if (m_hold == L) fire = 1;
      end
    end else begin
      m_hold = 0;
    end
`endif
    new_mode = m_pulse ? (m_mode + 1) % 3 : m_mode;
    if (fire) new_mode = 0;
    m_blink_t = (new_mode == 2 && m_mode == 2) ? m_blink_t + 1 : 0;
    m_led  = (new_mode == 1) || (new_mode == 2 && ((m_blink_t / H) % 2 == 0));
    m_mode = new_mode;

    m_pulse = m_stable & ~m_prev;
    m_prev  = m_stable;
    if (all_diff) m_stable = ~m_stable;
    m_k2 = m_k1;
    m_k1 = key;
  endtask

  // One clock: drive, advance model at the edge, compare at the falling edge.
  task automatic cyc(input bit key, input bit rst_n);
    key_in = key;
    rstn   = rst_n;
    @(posedge clk);
    model_edge(key, rst_n);
    @(negedge clk);
    chk("mode", mode, 2'(m_mode));
    chk("led_out", {1'b0, led_out}, {1'b0, m_led});
    chk("press_pulse", {1'b0, press_pulse}, {1'b0, m_pulse});
    log_mode.push_back(mode);
    log_led.push_back(led_out);
    log_pulse.push_back(press_pulse);
  endtask

  task automatic hold(input bit key, input int n);
    repeat (n) cyc(key, 1'b1);
  endtask

  function automatic int count_pulses(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b && i < log_pulse.size(); i++) if (log_pulse[i] === 1'b1) c++;
    return c;
  endfunction

  int  s;
  int  e;
  bit  rk;
  int  rn;
  logic [6:0] blink_pat;

  initial begin
    key_in = 1'b1;
    rstn   = 1'b0;

    // Reset with key held
    repeat (3) cyc(1'b1, 1'b0);
    chk("reset_mode", mode, 2'b00);
    chk("reset_led", {1'b0, led_out}, 2'b00);
    chk("reset_pulse", {1'b0, press_pulse}, 2'b00);
    hold(1'b0, 8);

    // Glitch shorter than D is ignored
    s = log_mode.size();
    hold(1'b1, 3);
    hold(1'b0, 8);
    chk("glitch_pulses", 2'(count_pulses(s, log_pulse.size() - 1)), 2'd0);
    chk("glitch_mode", log_mode[log_mode.size() - 1], 2'b00);

    // Clean press: mode/led change at edge k+7
    s = log_mode.size();
    hold(1'b1, 10);
    chk("clean_mode_k6", log_mode[s + 6], 2'b00);
    chk("clean_mode_k7", log_mode[s + 7], 2'b01);
    chk("clean_led_k7", {1'b0, log_led[s + 7]}, 2'b01);
    chk("clean_pulses", 2'(count_pulses(s, s + 9)), 2'd1);
    hold(1'b0, 8);

    // Full cycle from OFF
    cyc(1'b0, 1'b0);
    hold(1'b1, 10); hold(1'b0, 8);
    chk("cycle_p1", mode, 2'b01);
    s = log_mode.size();
    hold(1'b1, 10); hold(1'b0, 8);
    chk("cycle_p2", mode, 2'b10);
    e = -1;
    for (int i = s; i < log_mode.size(); i++) begin
      if (e < 0 && log_mode[i] === 2'b10) e = i;
    end
    chk("blink_entry_found", {1'b0, e >= 0}, 2'b01);
    if (e >= 0) begin
      blink_pat = 7'b1110001;
      for (int i = 0; i < 7; i++) begin
        chk("blink_pattern", {1'b0, log_led[e + i]}, {1'b0, blink_pat[6 - i]});
      end
    end
    hold(1'b1, 10); hold(1'b0, 8);
    chk("cycle_p3", mode, 2'b00);
    chk("cycle_p3_led", {1'b0, led_out}, 2'b00);

    // Reset while blinking
    hold(1'b1, 10); hold(1'b0, 8);
    hold(1'b1, 10); hold(1'b0, 2);
    chk("pre_rst_blink", mode, 2'b10);
    cyc(1'b0, 1'b0);
    chk("rst_blink_mode", mode, 2'b00);
    chk("rst_blink_led", {1'b0, led_out}, 2'b00);
    hold(1'b0, 6);
    hold(1'b1, 10); hold(1'b0, 8);
    chk("after_rst_press", mode, 2'b01);

`ifdef KEY_LONG_PRESS_EN
    // Long hold from OFF
    cyc(1'b0, 1'b0);
    hold(1'b0, 4);
    s = log_mode.size();
    hold(1'b1, 30);
    chk("long_k7", log_mode[s + 7], 2'b01);
    chk("long_k20", log_mode[s + 20], 2'b01);
    chk("long_k21", log_mode[s + 21], 2'b00);
    chk("long_k29", log_mode[s + 29], 2'b00);
    hold(1'b0, 8);
    chk("long_release", mode, 2'b00);
    chk("long_pulses", 2'(count_pulses(s, log_pulse.size() - 1)), 2'd1);
`endif

    // Randomized runs with occasional resets, checked against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        cyc(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        rk = 1'($urandom_range(0, 1));
        rn = $urandom_range(1, 12);
        hold(rk, rn);
      end
    end
    hold(1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
